// File: rtl/luma_sync_decoder.sv
// Luma sync decoder: slices and glitch-filters sync tips, classifies pulse widths, tracks raster counters and line lock.
// Pulses land GLITCH+1 cycles after the trailing edge; free-running, no backpressure. SYNC_HYST_EN adds slicer hysteresis.
module luma_sync_decoder #(
  parameter int SYNC_THRESH    = 6,
  parameter int SYNC_HYST      = 3,
  parameter int GLITCH         = 4,
  parameter int HSYNC_MIN      = 120,
  parameter int HSYNC_MAX      = 180,
  parameter int EQ_MIN         = 40,
  parameter int EQ_MAX         = 100,
  parameter int BROAD_MIN      = 400,
  parameter int LINE_MIN       = 1900,
  parameter int LINE_MAX       = 2200,
  parameter int LOCK_LINES     = 4,
  parameter int LINE_TICKS_MAX = 2400
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic [5:0]  luma_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        eq_o,
  output logic        sync_err_o,
  output logic [11:0] rec_x_o,
  output logic [8:0]  rec_y_o,
  output logic [11:0] line_len_o,
  output logic        locked_o
);

  localparam int GW = $clog2(GLITCH + 1);
  localparam int LW = $clog2(LOCK_LINES + 1);

  localparam logic [5:0]    THRESH   = 6'(SYNC_THRESH);
  localparam logic [GW-1:0] RUN_LAST = GW'(GLITCH - 1);
  localparam logic [10:0]   H_MIN    = 11'(HSYNC_MIN);
  localparam logic [10:0]   H_MAX    = 11'(HSYNC_MAX);
  localparam logic [10:0]   E_MIN    = 11'(EQ_MIN);
  localparam logic [10:0]   E_MAX    = 11'(EQ_MAX);
  localparam logic [10:0]   B_MIN    = 11'(BROAD_MIN);
  localparam logic [11:0]   L_MIN    = 12'(LINE_MIN);
  localparam logic [11:0]   L_MAX    = 12'(LINE_MAX);
  localparam logic [11:0]   T_MAX    = 12'(LINE_TICKS_MAX);
  localparam logic [11:0]   X_OFS    = 12'(GLITCH + 1);
  localparam logic [LW-1:0] LOCK_N   = LW'(LOCK_LINES);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state;
  logic          raw_low;
  logic          filt_low;
  logic          filt_d;
  logic [GW-1:0] run_cnt;
  logic [10:0]   width;
  logic [11:0]   space_cnt;
  logic          space_vld;
  logic [11:0]   tick_cnt;
  logic [1:0]    broad_cnt;
  logic          skip_chk;
  logic [LW-1:0] lock_cnt;

  logic          rise;
  logic          fall;
  logic          is_h;
  logic          is_eq;
  logic          is_broad;
  logic          is_err;
  logic          vsync_hit;
  logic          space_ok;
  logic [11:0]   tick_inc;
  logic [LW-1:0] lock_inc;

`ifdef SYNC_HYST_EN
  localparam logic [5:0] EXIT_LVL = 6'(SYNC_THRESH + SYNC_HYST);

  // Between the two levels the slice holds its previous decision.
  logic raw_q;

  always_comb begin
    raw_low = raw_q;
    if (luma_i < THRESH)
      raw_low = 1'b1;
    else if (luma_i > EXIT_LVL)
      raw_low = 1'b0;
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst)
      raw_q <= 1'b0;
    else
      raw_q <= raw_low;
  end
`else
  assign raw_low = (luma_i < THRESH);
`endif

  always_comb begin
    rise      = filt_d & ~filt_low;
    fall      = filt_low & ~filt_d;
    is_h      = rise && (width >= H_MIN) && (width <= H_MAX);
    is_eq     = rise && (width >= E_MIN) && (width <= E_MAX);
    is_broad  = rise && (width >= B_MIN);
    is_err    = rise && !is_h && !is_eq && !is_broad;
    vsync_hit = is_broad && (broad_cnt == 2'd2);
    space_ok  = space_vld && (space_cnt >= L_MIN) && (space_cnt <= L_MAX);
    tick_inc  = (tick_cnt == 12'hFFF) ? tick_cnt : tick_cnt + 12'd1;
    lock_inc  = lock_cnt + 1'b1;
  end

  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state      <= SEARCH;
      filt_low   <= 1'b0;
      filt_d     <= 1'b0;
      run_cnt    <= '0;
      width      <= '0;
      space_cnt  <= '0;
      space_vld  <= 1'b0;
      tick_cnt   <= '0;
      broad_cnt  <= '0;
      skip_chk   <= 1'b0;
      lock_cnt   <= '0;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      eq_o       <= 1'b0;
      sync_err_o <= 1'b0;
      rec_x_o    <= '0;
      rec_y_o    <= '0;
      line_len_o <= '0;
      locked_o   <= 1'b0;
    end else begin
      if (raw_low != filt_low) begin
        if (run_cnt == RUN_LAST) begin
          filt_low <= raw_low;
          run_cnt  <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
      filt_d <= filt_low;

      if (fall)
        width <= 11'd1;
      else if (filt_low && width != 11'h7FF)
        width <= width + 11'd1;

      hsync_o    <= is_h;
      eq_o       <= is_eq;
      sync_err_o <= is_err;
      vsync_o    <= vsync_hit;

      if (is_h)
        broad_cnt <= '0;
      else if (is_broad && broad_cnt != 2'd3)
        broad_cnt <= broad_cnt + 2'd1;

      if (is_h) begin
        space_cnt  <= 12'd1;
        line_len_o <= space_cnt;
        space_vld  <= 1'b1;
      end else if (space_cnt != 12'hFFF) begin
        space_cnt <= space_cnt + 12'd1;
      end

      // rec_x is referenced to the filtered falling edge, not to the classification cycle.
      if (is_h)
        rec_x_o <= {1'b0, width} + X_OFS;
      else if (rec_x_o != 12'hFFF)
        rec_x_o <= rec_x_o + 12'd1;

      if (vsync_hit)
        rec_y_o <= '0;
      else if (is_h && rec_y_o != 9'h1FF)
        rec_y_o <= rec_y_o + 9'd1;

      tick_cnt <= (is_h || is_eq || is_broad) ? 12'd0 : tick_inc;

      if (is_eq || is_broad)
        skip_chk <= 1'b1;
      else if (is_h)
        skip_chk <= 1'b0;

      // Vertical blanking drops hsyncs, so the first hsync after it carries a bogus spacing.
      if (is_h) begin
        case (state)
          SEARCH: begin
            if (space_ok) begin
              lock_cnt <= lock_inc;
              if (lock_inc == LOCK_N) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
              end
            end else begin
              lock_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!space_ok && !skip_chk) begin
              state    <= SEARCH;
              lock_cnt <= '0;
              locked_o <= 1'b0;
            end
          end
        endcase
      end else if (!is_eq && !is_broad && tick_inc == T_MAX) begin
        state    <= SEARCH;
        lock_cnt <= '0;
        locked_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_luma_sync_decoder.sv
// Directed bench for luma_sync_decoder: stimulus pushes expected pulses to a scoreboard,
// a negedge monitor pops and compares them when the DUT emits a pulse.
module tb_luma_sync_decoder;

  logic        clk_dot4x = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  luma_i = 6'd12;
  logic        hsync_o;
  logic        vsync_o;
  logic        eq_o;
  logic        sync_err_o;
  logic [11:0] rec_x_o;
  logic [8:0]  rec_y_o;
  logic [11:0] line_len_o;
  logic        locked_o;

  luma_sync_decoder dut (
    .clk_dot4x  (clk_dot4x),
    .rst        (rst),
    .luma_i     (luma_i),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .eq_o       (eq_o),
    .sync_err_o (sync_err_o),
    .rec_x_o    (rec_x_o),
    .rec_y_o    (rec_y_o),
    .line_len_o (line_len_o),
    .locked_o   (locked_o)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  int cyc = 0;
  always @(posedge clk_dot4x) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_H    = 4'b1000;
  localparam logic [3:0] K_V    = 4'b0100;
  localparam logic [3:0] K_EQ   = 4'b0010;
  localparam logic [3:0] K_ERR  = 4'b0001;

  // Fields set to -1 are not checked for that event.
  typedef struct {
    int         at;
    logic [3:0] kind;
    int         rx;
    int         ry;
    int         ll;
    logic       lk;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic [5:0] v);
    @(posedge clk_dot4x);
    #1;
    luma_i = v;
  endtask

  task automatic hold(input logic [5:0] v, input int n);
    repeat (n) step(v);
  endtask

  // w low samples, then blanking up to 'period' cycles; trailing edge at T gives the pulse at T+5.
  task automatic pulse(input int w, input int period, input logic [3:0] kind,
                       input int ry, input int ll, input logic lk, output int t_out);
    exp_t e;
    hold(6'd0, w);
    step(6'd12);
    e.at   = cyc + 5;
    e.kind = kind;
    e.rx   = (kind == K_H) ? w + 5 : -1;
    e.ry   = ry;
    e.ll   = ll;
    e.lk   = lk;
    if (kind != K_NONE) sb.push_back(e);
    t_out = e.at;
    hold(6'd12, period - w - 1);
  endtask

  always @(negedge clk_dot4x) begin
    if (rst === 1'b0 && (hsync_o | vsync_o | eq_o | sync_err_o) === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pulse_has_expectation", 32'(sb.size()), 32'd1);
      end else begin
        got = sb.pop_front();
        chk("pulse_kind", {28'd0, hsync_o, vsync_o, eq_o, sync_err_o}, {28'd0, got.kind});
        chk("pulse_cycle", cyc, got.at);
        if (got.rx >= 0) chk("rec_x", {20'd0, rec_x_o}, got.rx);
        if (got.ry >= 0) chk("rec_y", {23'd0, rec_y_o}, got.ry);
        if (got.ll >= 0) chk("line_len", {20'd0, line_len_o}, got.ll);
        chk("locked", {31'd0, locked_o}, {31'd0, got.lk});
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    int p1;
    int pf;

    // Reset held for 3 cycles while luma toggles.
    step(6'd0);
    step(6'd12);
    step(6'd0);
    chk("reset_outputs", {hsync_o, vsync_o, eq_o, sync_err_o, rec_x_o, rec_y_o, line_len_o, locked_o}, 32'd0);
    step(6'd12);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(6'd12);
      chk("post_reset_quiet", {hsync_o, vsync_o, eq_o, sync_err_o, rec_y_o, locked_o}, 32'd0);
    end

    // Single hsync: first blanking sample at T, hsync at T+5 with rec_x 153, rec_y 1.
    pulse(148, 168, K_H, 1, -1, 1'b0, p1);

    // 3-cycle dip is filtered; rec_x keeps counting from 153.
    hold(6'd0, 3);
    hold(6'd12, 100);
    chk("glitch_rec_x", {20'd0, rec_x_o}, 32'(153 + (cyc - p1)));

    // Lock acquisition: short first spacing, then 2080-cycle lines.
    pulse(148, 2080, K_H, 2, 271, 1'b0, t);
    for (int i = 1; i <= 5; i++)
      pulse(148, 2080, K_H, 2 + i, 2080, (i >= 4), t);

    // Equalization and out-of-window pulses while locked.
    pulse(60, 1040, K_EQ, 7, -1, 1'b1, t);
    pulse(250, 1040, K_ERR, 7, -1, 1'b1, t);
    pulse(148, 2080, K_H, 8, 4095, 1'b1, t);
    pulse(148, 2080, K_H, 9, 2080, 1'b1, t);

    // Vertical interval.
    for (int i = 0; i < 6; i++)
      pulse(74, 1040, K_EQ, 9, -1, 1'b1, t);
    for (int i = 0; i < 4; i++)
      pulse(900, 1040, (i == 2) ? K_V : K_NONE, 0, -1, 1'b1, t);
    for (int i = 0; i < 6; i++)
      pulse(74, 1040, K_EQ, 0, -1, 1'b1, t);
    pulse(148, 2080, K_H, 1, 4095, 1'b1, pf);

    // Timeout: lock drops exactly 2400 cycles after the last classified pulse.
    while (cyc < pf + 2399) step(6'd12);
    chk("lock_before_timeout", {31'd0, locked_o}, 32'd1);
    step(6'd12);
    chk("lock_after_timeout", {31'd0, locked_o}, 32'd0);

`ifdef SYNC_HYST_EN
    begin
      exp_t e;
      hold(6'd0, 20);
      for (int i = 0; i < 25; i++) begin
        step(6'd5);
        hold(6'd8, 4);
      end
      step(6'd12);
      e.at = cyc + 5; e.kind = K_H; e.rx = 150; e.ry = 2; e.ll = 4095; e.lk = 1'b0;
      sb.push_back(e);
      hold(6'd12, 20);
    end
`endif

    hold(6'd12, 10);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
